// File: rtl/vga_text_engine.sv
// vga_text_engine: programmable VGA raster with a 3-stage character-cell renderer.
// Define VGA_TEXT_CURSOR_EN to add a blinking underline cursor.
module vga_text_engine #(
  parameter int H_VISIBLE    = 1280,
  parameter int H_FP         = 48,
  parameter int H_SYNC       = 32,
  parameter int H_BP         = 80,
  parameter int V_VISIBLE    = 800,
  parameter int V_FP         = 3,
  parameter int V_SYNC       = 6,
  parameter int V_BP         = 22,
  parameter bit HSYNC_POL    = 1'b1,
  parameter bit VSYNC_POL    = 1'b1,
  parameter int CHAR_W       = 8,
  parameter int CHAR_H       = 16,
  parameter int COLS         = H_VISIBLE / CHAR_W,
  parameter int ROWS         = V_VISIBLE / CHAR_H,
  parameter int ADDR_W       = $clog2(COLS * ROWS),
  parameter int BLINK_FRAMES = 30
) (
  input  logic              clk,
  input  logic              reset,
`ifdef VGA_TEXT_CURSOR_EN
  input  logic              cursor_en,
  input  logic [$clog2(COLS)-1:0] cursor_col,
  input  logic [$clog2(ROWS)-1:0] cursor_row,
`endif
  output logic [ADDR_W-1:0] char_addr,
  input  logic [15:0]       char_data,
  output logic [11:0]       font_addr,
  input  logic [7:0]        font_row,
  output logic [7:0]        vga_red,
  output logic [7:0]        vga_green,
  output logic [7:0]        vga_blue,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic              video_on,
  output logic              frame_start
);
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);

  if (H_VISIBLE % CHAR_W != 0 || V_VISIBLE % CHAR_H != 0 || CHAR_W != 8 || BLINK_FRAMES < 1 || CHAR_H > 16)
    begin : g_bad_cfg
      $error("vga_text_engine: visible area must be a whole number of 8xCHAR_H cells");
    end

  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic          h_end, v_end, vis0, hit0, pix;
  logic [3:0]    row0, s1_row, s2_fg, s2_bg, clr;
  logic [2:0]    s1_col, s2_col;
  // control bundle: {visible, hsync active, vsync active, frame start, cursor hit}
  logic [4:0]    ctl0, s1_ctl, s2_ctl;

  function automatic logic [7:0] chan(input logic b, input logic i);
    return b ? (i ? 8'hFF : 8'hAA) : (i ? 8'h55 : 8'h00);
  endfunction

  assign h_end = hcount == HW'(H_TOTAL - 1);
  assign v_end = vcount == VW'(V_TOTAL - 1);
  assign vis0  = hcount < HW'(H_VISIBLE) && vcount < VW'(V_VISIBLE);
  assign row0  = 4'(32'(vcount) % CHAR_H);
  assign char_addr = vis0 ? ADDR_W'((32'(vcount) / CHAR_H) * COLS + 32'(hcount) / CHAR_W) : '0;
  assign ctl0 = {vis0,
                 hcount >= HW'(H_VISIBLE + H_FP) && hcount < HW'(H_VISIBLE + H_FP + H_SYNC),
                 vcount >= VW'(V_VISIBLE + V_FP) && vcount < VW'(V_VISIBLE + V_FP + V_SYNC),
                 hcount == '0 && vcount == '0,
                 hit0};

`ifdef VGA_TEXT_CURSOR_EN
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic          blink_wrap;
  assign blink_wrap = blink_cnt == BW'(BLINK_FRAMES - 1);
  // counting raster wraps makes the phase change land exactly on the next frame's first pixel
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (h_end && v_end) begin
      blink_cnt   <= blink_wrap ? '0 : blink_cnt + 1'b1;
      blink_phase <= blink_phase ^ blink_wrap;
    end
  assign hit0 = cursor_en && blink_phase && 32'(hcount) / CHAR_W == 32'(cursor_col) &&
                32'(vcount) / CHAR_H == 32'(cursor_row) && 32'(row0) >= 32'(CHAR_H - 2);
`else
  assign hit0 = 1'b0;
`endif

  assign font_addr = {char_data[7:0], s1_row};
  assign pix = font_row[3'd7 - s2_col] | s2_ctl[0];
  assign clr = pix ? s2_fg : s2_bg;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      hcount      <= '0;
      vcount      <= '0;
      s1_ctl      <= '0;
      s1_row      <= '0;
      s1_col      <= '0;
      s2_ctl      <= '0;
      s2_col      <= '0;
      s2_fg       <= '0;
      s2_bg       <= '0;
      vga_red     <= '0;
      vga_green   <= '0;
      vga_blue    <= '0;
      vga_hsync   <= !HSYNC_POL;
      vga_vsync   <= !VSYNC_POL;
      video_on    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hcount      <= h_end ? '0 : hcount + 1'b1;
      if (h_end) vcount <= v_end ? '0 : vcount + 1'b1;
      s1_ctl      <= ctl0;
      s1_row      <= row0;
      s1_col      <= hcount[2:0];
      s2_ctl      <= s1_ctl;
      s2_col      <= s1_col;
      s2_fg       <= char_data[11:8];
      s2_bg       <= char_data[15:12];
      vga_red     <= s2_ctl[4] ? chan(clr[2], clr[3]) : 8'h00;
      vga_green   <= s2_ctl[4] ? chan(clr[1], clr[3]) : 8'h00;
      vga_blue    <= s2_ctl[4] ? chan(clr[0], clr[3]) : 8'h00;
      vga_hsync   <= s2_ctl[3] ~^ HSYNC_POL;
      vga_vsync   <= s2_ctl[2] ~^ VSYNC_POL;
      video_on    <= s2_ctl[4];
      frame_start <= s2_ctl[1];
    end
endmodule

// File: tb/tb_vga_text_engine.sv
// tb_vga_text_engine: scoreboard bench on a small raster; cursor checks when VGA_TEXT_CURSOR_EN is defined.
module tb_vga_text_engine;
  localparam int HV = 48, HFP = 4, HS = 6, HBP = 4, HT = HV + HFP + HS + HBP;
  localparam int VV = 48, VFP = 2, VS = 3, VBP = 2, VT = VV + VFP + VS + VBP;
  localparam int CH = 16, COLS = HV / 8, ROWS = VV / CH, AW = 5, BLINK = 2;
  localparam bit HP = 1'b0, VP = 1'b1;

  typedef struct packed {
    logic [7:0] r, g, b;
    logic hs, vs, von, fs;
  } out_t;

  logic clk = 1'b0, reset = 1'b1, cen = 1'b0, cur_vis = 1'b0;
  logic [AW-1:0] char_addr;
  logic [15:0] char_data = '0;
  logic [11:0] font_addr;
  logic [7:0] font_row = '0, vga_red, vga_green, vga_blue;
  logic vga_hsync, vga_vsync, video_on, frame_start;
  logic [15:0] cmem [COLS*ROWS];
  out_t q[$];
  out_t rst_o, e;
  int errors = 0, checks = 0, mh = 0, mv = 0, frame = 0;

  always #5 clk = ~clk;

  vga_text_engine #(
    .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .HSYNC_POL(HP), .VSYNC_POL(VP), .CHAR_H(CH), .BLINK_FRAMES(BLINK)
  ) dut (
    .clk(clk), .reset(reset),
`ifdef VGA_TEXT_CURSOR_EN
    .cursor_en(cen), .cursor_col(3'd3), .cursor_row(2'd2),
`endif
    .char_addr(char_addr), .char_data(char_data), .font_addr(font_addr), .font_row(font_row),
    .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .video_on(video_on), .frame_start(frame_start)
  );

  function automatic logic [7:0] font_f(input logic [11:0] a);
    logic [7:0] x;
    x = a[11:4] * 8'd37;
    x = x + {a[3:0], a[3:0]};
    return (a == 12'h410) ? 8'h18 : x ^ 8'h5A;
  endfunction

  function automatic logic [7:0] pal(input logic b, input logic i);
    if (b) return i ? 8'hFF : 8'hAA;
    return i ? 8'h55 : 8'h00;
  endfunction

  // blanking reads return a loud pattern so a missing blank shows up in RGB
  always @(posedge clk) begin
    char_data <= cur_vis ? cmem[char_addr] : 16'hFFDB;
    font_row  <= font_f(font_addr);
  end

  function automatic out_t expect_at(input int h, input int v, input logic hit);
    out_t o;
    logic vis, px;
    logic [15:0] c;
    logic [7:0] fr;
    logic [3:0] k;
    vis = h < HV && v < VV;
    c = vis ? cmem[(v / CH) * COLS + h / 8] : 16'hFFDB;
    fr = font_f({c[7:0], 4'(v % CH)});
    px = fr[7 - h % 8] | hit;
    k = px ? c[11:8] : c[15:12];
    o.r = vis ? pal(k[2], k[3]) : 8'h00;
    o.g = vis ? pal(k[1], k[3]) : 8'h00;
    o.b = vis ? pal(k[0], k[3]) : 8'h00;
    o.hs = (h >= HV + HFP && h < HV + HFP + HS) ? HP : !HP;
    o.vs = (v >= VV + VFP && v < VV + VFP + VS) ? VP : !VP;
    o.von = vis;
    o.fs = h == 0 && v == 0;
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s at t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  task automatic step();
    logic hit;
    hit = 1'b0;
`ifdef VGA_TEXT_CURSOR_EN
    hit = cen && ((frame / BLINK) % 2 == 1) && mh / 8 == 3 && mv / CH == 2 && mv % CH >= CH - 2;
`endif
    chk("char_addr", 32'(char_addr), (mh < HV && mv < VV) ? 32'((mv / CH) * COLS + mh / 8) : 32'd0);
    q.push_back(expect_at(mh, mv, hit));
    e = q.pop_front();
    chk("pixel", 32'({vga_red, vga_green, vga_blue, vga_hsync, vga_vsync, video_on, frame_start}), 32'(e));
    cur_vis = mh < HV && mv < VV;
    mh++;
    if (mh == HT) begin
      mh = 0;
      mv++;
      if (mv == VT) begin
        mv = 0;
        frame++;
      end
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic restart();
    q.delete();
    repeat (3) q.push_back(rst_o);
    mh = 0;
    mv = 0;
    frame = 0;
    cur_vis = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rgb"}, 32'({vga_red, vga_green, vga_blue}), 32'd0);
    chk({tag, "_hsync"}, 32'(vga_hsync), 32'(!HP));
    chk({tag, "_vsync"}, 32'(vga_vsync), 32'(!VP));
    chk({tag, "_video_on"}, 32'(video_on), 32'd0);
    chk({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    chk({tag, "_char_addr"}, 32'(char_addr), 32'd0);
  endtask

  initial begin
    rst_o = '{r: 8'h00, g: 8'h00, b: 8'h00, hs: !HP, vs: !VP, von: 1'b0, fs: 1'b0};
    for (int i = 0; i < COLS * ROWS; i++) cmem[i] = 16'($urandom);
    cmem[0] = 16'h1F41;
    cmem[15] = 16'h1E20;
    cen = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    reset = 1'b0;
    restart();
    run(HT * VT + 30 * HT + 20);
    reset = 1'b1;
    #1;
    chk_reset("midreset");
    @(negedge clk);
    @(negedge clk);
    chk_reset("midreset_hold");
    reset = 1'b0;
    restart();
    run(6 * HT * VT);
    cen = 1'b0;
    run(2 * HT * VT);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
